// File: rtl/dpc_pkg.sv
// Shared types and geometry helpers for the dead-pixel-correction controller.
package dpc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } dpc_ctrl_state_e;

  localparam int unsigned PixW = 24;

  // RGB888 pixel
  typedef logic [PixW-1:0] pixel_t;

  // Number of datapath shift stages between input and last stage.
  function automatic int unsigned depth(input int unsigned h);
    return 4 * h + 4;
  endfunction

  // Shifts from datapath entry to the window-centre slot.
  function automatic int unsigned ctr_ofs(input int unsigned h);
    return 2 * h + 2;
  endfunction

endpackage

// File: rtl/dpc_ctrl_if.sv
// Pixel stream and datapath-control bundle of the DPC controller.
interface dpc_ctrl_if;
  import dpc_pkg::*;

  // Upstream stream
  logic   s_valid;
  logic   s_ready;
  logic   s_sof;
  pixel_t s_data;
  // Downstream stream
  logic   m_valid;
  logic   m_ready;
  logic   m_sof;
  logic   m_eol;
  pixel_t m_data;
  // Line-buffer datapath
  logic   dp_en;
  pixel_t dp_data_in;
  pixel_t dp_data_out;
  logic   dp_ctr_interior;

  // Controller side
  modport slave (
    input  s_valid, s_sof, s_data, m_ready, dp_data_out,
    output s_ready, m_valid, m_sof, m_eol, m_data, dp_en, dp_data_in, dp_ctr_interior
  );

  // Environment side: upstream source, downstream sink and datapath
  modport master (
    output s_valid, s_sof, s_data, m_ready, dp_data_out,
    input  s_ready, m_valid, m_sof, m_eol, m_data, dp_en, dp_data_in, dp_ctr_interior
  );

endinterface

// File: rtl/dpc_pos_cnt.sv
// Raster row/column counter: clear wins over step, column wraps at H, row wraps at V.
module dpc_pos_cnt #(
  parameter int unsigned H = 1280,
  parameter int unsigned V = 720,
  localparam int unsigned ColW = (H > 1) ? $clog2(H) : 1,
  localparam int unsigned RowW = (V > 1) ? $clog2(V) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            step,
  output logic [ColW-1:0] col,
  output logic [RowW-1:0] row
);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  // Next position: clear, or advance one pixel in raster order
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (step) begin
      if (col_q == ColW'(H - 1)) begin
        col_d = '0;
        row_d = (row_q == RowW'(V - 1)) ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/dpc_ctrl.sv
// Stream sequencer for the DPC line-buffer datapath: drives the shift enable,
// back-pressures upstream, zero-fill drains at end of frame and tags outputs.
module dpc_ctrl
  import dpc_pkg::*;
#(
  parameter int unsigned H = 1280,
  parameter int unsigned V = 720
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       abort,
  dpc_ctrl_if.slave  bus,
  output logic       busy,
  output logic       err_sof,
  output logic       err_drop
);

  localparam int unsigned N     = H * V;
  localparam int unsigned Depth = depth(H);
  localparam int unsigned Ctr   = ctr_ofs(H);
  localparam int unsigned CntW  = $clog2(N + Depth + 1);
  localparam int unsigned ColW  = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned RowW  = (V > 1) ? $clog2(V) : 1;

  dpc_ctrl_state_e state_q, state_d;
  logic [CntW-1:0] shift_cnt_q, shift_cnt_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic            err_sof_q, err_sof_d;
  logic            err_drop_q, err_drop_d;

  logic            m_valid;
  logic            stall;
  logic            out_fire;
  logic            ctr_clr, ctr_step, ctr_valid;
  logic            out_clr;
  logic [ColW-1:0] ctr_col, o_col;
  logic [RowW-1:0] ctr_row, o_row;

  // Output decode from registered counters only. The pending pixel is the one
  // whose shift count is exactly Depth ahead of the output count, so a fire
  // without a shift (upstream idle) consumes it once instead of repeating it.
  always_comb begin
    m_valid = (state_q != StIdle) && (out_cnt_q < CntW'(N)) &&
              (out_cnt_q + CntW'(Depth) == shift_cnt_q);
    ctr_valid = (state_q != StIdle) && (shift_cnt_q >= CntW'(Ctr)) &&
                (shift_cnt_q < CntW'(Ctr + N));
    bus.m_valid = m_valid;
    bus.m_sof   = m_valid && (out_cnt_q == '0);
    bus.m_eol   = m_valid && (o_col == ColW'(H - 1));
    bus.m_data  = bus.dp_data_out;
    bus.dp_ctr_interior = ctr_valid &&
                          (32'(ctr_row) >= 32'd2) && (32'(ctr_row) <= V - 32'd3) &&
                          (32'(ctr_col) >= 32'd2) && (32'(ctr_col) <= H - 32'd3);
  end

  assign stall    = m_valid && !bus.m_ready;
  assign out_fire = m_valid && bus.m_ready;

  // Sequencer next state, handshake and shift enable
  always_comb begin
    state_d        = state_q;
    shift_cnt_d    = shift_cnt_q;
    out_cnt_d      = out_cnt_q;
    err_sof_d      = err_sof_q;
    err_drop_d     = 1'b0;
    bus.s_ready    = 1'b0;
    bus.dp_en      = 1'b0;
    bus.dp_data_in = '0;
    ctr_clr        = 1'b0;
    out_clr        = 1'b0;

    if (abort) begin
      // Datapath contents are left stale; the next frame overwrites them
      state_d     = StIdle;
      shift_cnt_d = '0;
      out_cnt_d   = '0;
      ctr_clr     = 1'b1;
      out_clr     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          bus.s_ready    = 1'b1;
          bus.dp_data_in = bus.s_data;
          if (bus.s_valid) begin
            if (bus.s_sof) begin
              bus.dp_en   = 1'b1;
              shift_cnt_d = CntW'(1);
              out_cnt_d   = '0;
              ctr_clr     = 1'b1;
              out_clr     = 1'b1;
              state_d     = StRun;
            end else begin
              err_drop_d = 1'b1;
            end
          end
        end
        StRun: begin
          bus.s_ready    = !stall;
          bus.dp_en      = bus.s_valid && !stall;
          bus.dp_data_in = bus.s_data;
          if (bus.dp_en) begin
            shift_cnt_d = shift_cnt_q + CntW'(1);
            if (bus.s_sof) err_sof_d = 1'b1;
            if (shift_cnt_q + CntW'(1) == CntW'(N)) state_d = StFlush;
          end
          if (out_fire) out_cnt_d = out_cnt_q + CntW'(1);
        end
        StFlush: begin
          bus.dp_en = !stall && (shift_cnt_q < CntW'(N + Depth - 1));
          if (bus.dp_en) shift_cnt_d = shift_cnt_q + CntW'(1);
          if (out_fire) begin
            out_cnt_d = out_cnt_q + CntW'(1);
            if (out_cnt_q == CntW'(N - 1)) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign ctr_step = bus.dp_en && (shift_cnt_q >= CntW'(Ctr));

  // Controller state and counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      shift_cnt_q <= '0;
      out_cnt_q   <= '0;
      err_sof_q   <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      out_cnt_q   <= out_cnt_d;
      err_sof_q   <= err_sof_d;
      err_drop_q  <= err_drop_d;
    end
  end

  dpc_pos_cnt #(.H(H), .V(V)) u_ctr_pos (
    .clk  (clk),
    .rstn (rstn),
    .clr  (ctr_clr),
    .step (ctr_step),
    .col  (ctr_col),
    .row  (ctr_row)
  );

  dpc_pos_cnt #(.H(H), .V(V)) u_out_pos (
    .clk  (clk),
    .rstn (rstn),
    .clr  (out_clr),
    .step (out_fire),
    .col  (o_col),
    .row  (o_row)
  );

  assign busy     = (state_q != StIdle);
  assign err_sof  = err_sof_q;
  assign err_drop = err_drop_q;

  // Output row is kept for completeness of the position; only the column is decoded
  logic unused_o_row;
  assign unused_o_row = ^o_row;

endmodule

// File: tb/tb_dpc_ctrl.sv
// Scoreboard bench for dpc_ctrl with a behavioural shift-register datapath.
module tb_dpc_ctrl;

  localparam int H = 8;
  localparam int V = 6;
  localparam int N = H * V;
  localparam int DEPTH = 4 * H + 4;
  localparam int CTR = 2 * H + 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic abort = 1'b0;
  logic busy, err_sof, err_drop;

  dpc_ctrl_if bus ();

  dpc_ctrl #(.H(H), .V(V)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .abort    (abort),
    .bus      (bus.slave),
    .busy     (busy),
    .err_sof  (err_sof),
    .err_drop (err_drop)
  );

  always #5 clk = ~clk;

  // Datapath: DEPTH-stage shift register advanced by dp_en
  logic [23:0] pipe [DEPTH];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else if (bus.dp_en) begin
      pipe[0] <= bus.dp_data_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.dp_data_out = pipe[DEPTH-1];

  typedef struct packed {
    logic [23:0] data;
    logic        sof;
    logic        eol;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int f, input int k);
    return 24'((f + 1) * 65536 + k * 256 + (k ^ 8'h5a));
  endfunction

  // Bench model of the frame, updated from observed handshakes
  int sh = 0, oc = 0, fires = 0, first_mv = -1, int_cnt = 0, drop_cnt = 0, en_total = 0;
  bit active = 0, seen_mv = 0;
  int mode = 0;
  int cyc = 0;

  // Downstream ready pattern: 0 always ready, 1 stall one cycle in three, 2 never
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      bus.m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 != 0) : 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every output fire, checks stall rules and interior flag
  always @(negedge clk) begin
    exp_t e;
    int   c;
    bit   exp_int;
    if (rstn) begin
      c = sh - CTR;
      exp_int = active && (sh >= CTR) && (sh < CTR + N) && (c / H >= 2) && (c / H <= V - 3) &&
                (c % H >= 2) && (c % H <= H - 3);
      chk("interior", bus.dp_ctr_interior, exp_int);
      if (exp_int) int_cnt++;
      if (bus.m_valid && !seen_mv) begin
        seen_mv  = 1;
        first_mv = sh;
      end
      if (bus.m_valid && !bus.m_ready) begin
        chk("stall_dp_en", bus.dp_en, 0);
        chk("stall_s_ready", bus.s_ready, 0);
      end
      if (err_drop) drop_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got output %h, required none", bus.m_data);
        end else begin
          e = q.pop_front();
          chk("m_data", bus.m_data, e.data);
          chk("m_sof", bus.m_sof, e.sof);
          chk("m_eol", bus.m_eol, e.eol);
          chk("latency", sh - oc, DEPTH);
        end
        fires++;
        oc++;
        if (oc == N) active = 0;
      end
      if (bus.dp_en) en_total++;
      if (abort) begin
        active = 0;
        sh = 0;
        oc = 0;
      end else if (bus.dp_en) begin
        if (!active) begin
          active = 1;
          sh = 1;
          oc = 0;
        end else begin
          sh++;
        end
      end
    end
  end

  int fnum = 0;

  task automatic clear_stats();
    fires = 0;
    int_cnt = 0;
    seen_mv = 0;
    first_mv = -1;
  endtask

  // Drive one frame; a second sof at sof_at, abort under stall before pixel abort_at
  task automatic send_frame(input int sof_at, input int abort_at);
    bit ok;
    logic [23:0] d;
    for (int k = 0; k < N; k++) begin
      if (k == abort_at) begin
        mode = 2;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("abort_stall", bus.m_valid & ~bus.m_ready, 1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_stall_hold", bus.m_valid & ~bus.m_ready, 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_m_valid", bus.m_valid, 0);
        chk("abort_err_sof", err_sof, 1);
        q.delete();
        mode = 0;
        @(posedge clk);
        #1;
        fnum++;
        return;
      end
      d = pix(fnum, k);
      bus.s_valid = 1'b1;
      bus.s_sof   = (k == 0) || (k == sof_at);
      bus.s_data  = d;
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge clk);
        ok = bus.s_ready;
        @(posedge clk);
        #1;
      end
      if (!ok) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: got no s_ready for pixel %0d, required accept", k);
        bus.s_valid = 1'b0;
        return;
      end
      q.push_back('{data: d, sof: (k == 0), eol: (k % H == H - 1)});
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    fnum++;
  endtask

  task automatic wait_done(input string name, input bit check_int);
    for (int t = 0; t < 2000 && active; t++) @(posedge clk);
    if (active) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got frame still active, required completion", name);
    end
    @(negedge clk);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_fires"}, fires, N);
    chk({name, "_shifts"}, sh, N + DEPTH - 1);
    chk({name, "_first_mv"}, first_mv, DEPTH);
    chk({name, "_q_empty"}, q.size(), 0);
    if (check_int) chk({name, "_interior_cnt"}, int_cnt, 8);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int en0;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_data  = '0;

    // Reset values
    @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_sof", bus.m_sof, 0);
    chk("rst_m_eol", bus.m_eol, 0);
    chk("rst_dp_en", bus.dp_en, 0);
    chk("rst_interior", bus.dp_ctr_interior, 0);
    chk("rst_err_sof", err_sof, 0);
    chk("rst_err_drop", err_drop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Continuous frame, always ready
    mode = 0;
    clear_stats();
    send_frame(-1, -1);
    wait_done("cont", 1);
    chk("cont_err_sof", err_sof, 0);

    // Downstream stalls one cycle in three
    mode = 1;
    clear_stats();
    send_frame(-1, -1);
    wait_done("stall", 0);
    mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Non-sof pixels in IDLE are dropped, then a sof starts the frame
    drop_cnt = 0;
    en0 = en_total;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_sof   = 1'b0;
      bus.s_data  = 24'(i + 24'h00ab00);
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("drop_pulses", drop_cnt, 3);
    chk("drop_no_dp_en", en_total - en0, 0);
    chk("drop_busy", busy, 0);
    clear_stats();
    send_frame(-1, -1);
    wait_done("after_drop", 1);

    // Stray sof on accepted pixel 20
    clear_stats();
    send_frame(20, -1);
    wait_done("sof20", 1);
    chk("sof20_err_sof", err_sof, 1);

    // Abort at shift 40 while stalled, then a clean frame
    clear_stats();
    send_frame(-1, 40);
    clear_stats();
    send_frame(-1, -1);
    wait_done("post_abort", 1);
    chk("post_abort_err_sof", err_sof, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
